// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler.
// Tracks which entries are busy and which operands are still waiting on a ROB tag.
// An age matrix records allocation order.
// Each cycle it picks the oldest ready entry for the ALU, and it reports the lowest free slot to Dispatch.
module rs_issue_scheduler #(
  parameter int SIZE  = 16,
  parameter int IDX_W = 4,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             alloc_valid,
  output logic [IDX_W-1:0] alloc_pos,
  output logic             alloc_ok,
  input  logic             alloc_j_pend,
  input  logic [ROB_W-1:0] alloc_j_tag,
  input  logic             alloc_k_pend,
  input  logic [ROB_W-1:0] alloc_k_tag,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_tag,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_tag,
  input  logic             alu_free,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_pos,
  output logic             full,
  output logic [IDX_W:0]   count
);

  // Per-entry state; older_q[a][b] = 1 means entry a was allocated before entry b.
  logic [SIZE-1:0]  busy_q, busy_d;
  logic [SIZE-1:0]  jp_q, jp_d;
  logic [SIZE-1:0]  kp_q, kp_d;
  logic [ROB_W-1:0] jt_q [SIZE];
  logic [ROB_W-1:0] jt_d [SIZE];
  logic [ROB_W-1:0] kt_q [SIZE];
  logic [ROB_W-1:0] kt_d [SIZE];
  logic [SIZE-1:0]  older_q [SIZE];
  logic [SIZE-1:0]  older_d [SIZE];
  logic             issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0] issue_pos_q, issue_pos_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [SIZE-1:0]  ready;
  logic [SIZE-1:0]  grant;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             do_alloc;
  logic             do_sel;

  // True when either valid CDB broadcast carries this tag.
  function automatic logic tag_hit(input logic [ROB_W-1:0] t);
    return (cdb_alu_valid && (cdb_alu_tag == t)) || (cdb_lsb_valid && (cdb_lsb_tag == t));
  endfunction

  // Readiness comes from registered state only, so same-cycle wakeups wait a cycle.
  assign ready = busy_q & ~jp_q & ~kp_q;

  assign full        = (count_q == (IDX_W+1)'(SIZE));
  assign alloc_ok    = ~full;
  assign alloc_pos   = free_idx;
  assign issue_valid = issue_valid_q;
  assign issue_pos   = issue_pos_q;
  assign count       = count_q;

  // An entry is granted when it is ready and no older entry is also ready.
  always_comb begin
    grant = '0;
    for (int e = 0; e < SIZE; e++) begin
      grant[e] = ready[e];
      for (int x = 0; x < SIZE; x++) begin
        if (ready[x] && older_q[x][e]) grant[e] = 1'b0;
      end
    end
  end

  // Priority encoders: the granted entry, and the lowest free slot (0 when full).
  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    for (int e = SIZE - 1; e >= 0; e--) begin
      if (grant[e])   sel_idx  = e[IDX_W-1:0];
      if (!busy_q[e]) free_idx = e[IDX_W-1:0];
    end
  end

  // Next state: flush, stall, or normal operation (wakeup, allocation, selection).
  always_comb begin
    busy_d        = busy_q;
    jp_d          = jp_q;
    kp_d          = kp_q;
    jt_d          = jt_q;
    kt_d          = kt_q;
    older_d       = older_q;
    issue_valid_d = 1'b0;
    issue_pos_d   = issue_pos_q;
    count_d       = count_q;
    do_alloc      = 1'b0;
    do_sel        = 1'b0;
    if (clr) begin
      busy_d      = '0;
      older_d     = '{default: '0};
      issue_pos_d = '0;
      count_d     = '0;
    end else if (rdy) begin
      for (int e = 0; e < SIZE; e++) begin
        if (busy_q[e] && jp_q[e] && tag_hit(jt_q[e])) jp_d[e] = 1'b0;
        if (busy_q[e] && kp_q[e] && tag_hit(kt_q[e])) kp_d[e] = 1'b0;
      end
      do_alloc = alloc_valid && !full;
      if (do_alloc) begin
        busy_d[free_idx]  = 1'b1;
        jp_d[free_idx]    = alloc_j_pend && !tag_hit(alloc_j_tag);
        kp_d[free_idx]    = alloc_k_pend && !tag_hit(alloc_k_tag);
        jt_d[free_idx]    = alloc_j_tag;
        kt_d[free_idx]    = alloc_k_tag;
        older_d[free_idx] = '0;
        // The new slot was free, so busy_q[free_idx] is 0 and the slot is never marked older than itself.
        for (int x = 0; x < SIZE; x++) older_d[x][free_idx] = busy_q[x];
      end
      do_sel = alu_free && (|grant);
      if (do_sel) begin
        busy_d[sel_idx]  = 1'b0;
        older_d[sel_idx] = '0;
        for (int x = 0; x < SIZE; x++) older_d[x][sel_idx] = 1'b0;
        issue_valid_d    = 1'b1;
        issue_pos_d      = sel_idx;
      end
      count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_sel);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q        <= '0;
      jp_q          <= '0;
      kp_q          <= '0;
      jt_q          <= '{default: '0};
      kt_q          <= '{default: '0};
      older_q       <= '{default: '0};
      issue_valid_q <= 1'b0;
      issue_pos_q   <= '0;
      count_q       <= '0;
    end else begin
      busy_q        <= busy_d;
      jp_q          <= jp_d;
      kp_q          <= kp_d;
      jt_q          <= jt_d;
      kt_q          <= kt_d;
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_pos_q   <= issue_pos_d;
      count_q       <= count_d;
    end
  end

endmodule
